// File: rtl/irb_pkg.sv
// Shared types and constants for the inverted-residual-block scheduler slice.
package irb_pkg;

    localparam int DEF_TXY_W  = 8;
    localparam int DEF_GRP_W  = 11;
    localparam int DEF_PERF_W = 32;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_LD_FMI,
        ST_LD_KEX,
        ST_CONV_GO,
        ST_CONV_WAIT,
        ST_STORE,
        ST_NEXT,
        ST_DONE
    } statetype;

    localparam logic [1:0] DMA_LD_FMI   = 2'd0;
    localparam logic [1:0] DMA_LD_KEX   = 2'd1;
    localparam logic [1:0] DMA_ST_FMINT = 2'd2;

endpackage

// File: rtl/irb_conv11_scheduler_if.sv
// Layer-control, DMA and conv-engine signals of the 1*1 conv scheduler.
interface irb_conv11_scheduler_if
    import irb_pkg::*;
#(
    parameter int TXY_W = DEF_TXY_W,
    parameter int GRP_W = DEF_GRP_W
);
    logic             start;
    logic [TXY_W-1:0] n_tiles_x;
    logic [TXY_W-1:0] n_tiles_y;
    logic [GRP_W-1:0] n_groups;
    logic             dma_req;
    logic [1:0]       dma_op;
    logic [TXY_W-1:0] dma_tile_x;
    logic [TXY_W-1:0] dma_tile_y;
    logic [GRP_W-1:0] dma_group;
    logic             dma_ack;
    logic             conv_start;
    logic             conv_finish;
    logic             busy;
    logic             done;

    modport master (
        input  start, n_tiles_x, n_tiles_y, n_groups, dma_ack, conv_finish,
        output dma_req, dma_op, dma_tile_x, dma_tile_y, dma_group, conv_start, busy, done
    );

    modport slave (
        output start, n_tiles_x, n_tiles_y, n_groups, dma_ack, conv_finish,
        input  dma_req, dma_op, dma_tile_x, dma_tile_y, dma_group, conv_start, busy, done
    );

endinterface

// File: rtl/irb_tile_counter.sv
// Nested group -> tile column -> tile row counter with last-group / last-tile flags.
module irb_tile_counter
    import irb_pkg::*;
#(
    parameter int TXY_W = DEF_TXY_W,
    parameter int GRP_W = DEF_GRP_W
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             clr,
    input  logic             step,
    input  logic [TXY_W-1:0] n_x,
    input  logic [TXY_W-1:0] n_y,
    input  logic [GRP_W-1:0] n_grp,
    output logic [TXY_W-1:0] tx,
    output logic [TXY_W-1:0] ty,
    output logic [GRP_W-1:0] grp,
    output logic             grp_last,
    output logic             tile_last
);

    logic [TXY_W-1:0] tx_q, tx_d, ty_q, ty_d;
    logic [GRP_W-1:0] grp_q, grp_d;
    logic             x_last, y_last;

    // Counts are non-zero whenever step is used, so count-1 never wraps.
    assign grp_last  = (grp_q == n_grp - GRP_W'(1));
    assign x_last    = (tx_q == n_x - TXY_W'(1));
    assign y_last    = (ty_q == n_y - TXY_W'(1));
    assign tile_last = x_last && y_last;

    always_comb begin
        tx_d  = tx_q;
        ty_d  = ty_q;
        grp_d = grp_q;
        if (clr) begin
            tx_d  = '0;
            ty_d  = '0;
            grp_d = '0;
        end else if (step) begin
            if (!grp_last) begin
                grp_d = grp_q + GRP_W'(1);
            end else begin
                grp_d = '0;
                if (!x_last) begin
                    tx_d = tx_q + TXY_W'(1);
                end else begin
                    tx_d = '0;
                    if (!y_last) ty_d = ty_q + TXY_W'(1);
                end
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            tx_q  <= '0;
            ty_q  <= '0;
            grp_q <= '0;
        end else begin
            tx_q  <= tx_d;
            ty_q  <= ty_d;
            grp_q <= grp_d;
        end
    end

    assign tx  = tx_q;
    assign ty  = ty_q;
    assign grp = grp_q;

endmodule

// File: rtl/irb_conv11_scheduler.sv
// Tile/group sequencer for the 1*1 conv engine: FMI load, then per group KEX load, conv, FMINT store.
// Define IRB_SCHED_PERF_EN to add the busy/stall performance counters.
module irb_conv11_scheduler
    import irb_pkg::*;
#(
    parameter int TXY_W = DEF_TXY_W,
    parameter int GRP_W = DEF_GRP_W
`ifdef IRB_SCHED_PERF_EN
    ,
    parameter int PERF_W = DEF_PERF_W
`endif
) (
    input  logic clk,
    input  logic rst,
    irb_conv11_scheduler_if.master bus
`ifdef IRB_SCHED_PERF_EN
    ,
    output logic [PERF_W-1:0] perf_busy_cyc,
    output logic [PERF_W-1:0] perf_stall_cyc
`endif
);

    statetype         state_q, state_d;
    logic [TXY_W-1:0] cfg_x_q, cfg_x_d, cfg_y_q, cfg_y_d;
    logic [GRP_W-1:0] cfg_g_q, cfg_g_d;
    logic             dma_req_q, dma_req_d, conv_start_q, conv_start_d;
    logic             busy_q, busy_d, done_q, done_d;
    logic [1:0]       dma_op_q, dma_op_d;
    logic             start_acc, ack_acc, grp_last, tile_last;
    logic [TXY_W-1:0] tx, ty;
    logic [GRP_W-1:0] grp;

    assign start_acc = (state_q == ST_IDLE) && bus.start;
    // Only an ack seen while the request is actually up counts.
    assign ack_acc   = dma_req_q && bus.dma_ack;

    irb_tile_counter #(.TXY_W(TXY_W), .GRP_W(GRP_W)) u_cnt (
        .clk       (clk),
        .rst       (rst),
        .clr       (start_acc),
        .step      (state_q == ST_NEXT),
        .n_x       (cfg_x_q),
        .n_y       (cfg_y_q),
        .n_grp     (cfg_g_q),
        .tx        (tx),
        .ty        (ty),
        .grp       (grp),
        .grp_last  (grp_last),
        .tile_last (tile_last)
    );

    always_comb begin
        state_d = state_q;
        cfg_x_d = cfg_x_q;
        cfg_y_d = cfg_y_q;
        cfg_g_d = cfg_g_q;
        case (state_q)
            ST_IDLE: begin
                if (bus.start) begin
                    cfg_x_d = bus.n_tiles_x;
                    cfg_y_d = bus.n_tiles_y;
                    cfg_g_d = bus.n_groups;
                    if (bus.n_tiles_x == '0 || bus.n_tiles_y == '0 || bus.n_groups == '0)
                        state_d = ST_DONE;
                    else
                        state_d = ST_LD_FMI;
                end
            end
            ST_LD_FMI:    if (ack_acc) state_d = ST_LD_KEX;
            ST_LD_KEX:    if (ack_acc) state_d = ST_CONV_GO;
            ST_CONV_GO:   state_d = ST_CONV_WAIT;
            ST_CONV_WAIT: if (bus.conv_finish) state_d = ST_STORE;
            ST_STORE:     if (ack_acc) state_d = ST_NEXT;
            ST_NEXT: begin
                if (!grp_last)     state_d = ST_LD_KEX;
                else if (tile_last) state_d = ST_DONE;
                else               state_d = ST_LD_FMI;
            end
            ST_DONE:      state_d = ST_IDLE;
            default:      state_d = ST_IDLE;
        endcase

        // Dropping the request for the cycle after an ack guarantees a low gap between transactions.
        dma_req_d    = (state_d == ST_LD_FMI || state_d == ST_LD_KEX || state_d == ST_STORE) && !ack_acc;
        dma_op_d     = (state_d == ST_LD_KEX) ? DMA_LD_KEX :
                       (state_d == ST_STORE)  ? DMA_ST_FMINT : DMA_LD_FMI;
        conv_start_d = (state_d == ST_CONV_GO);
        busy_d       = (state_d != ST_IDLE);
        done_d       = (state_q == ST_DONE);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q      <= ST_IDLE;
            cfg_x_q      <= '0;
            cfg_y_q      <= '0;
            cfg_g_q      <= '0;
            dma_req_q    <= 1'b0;
            dma_op_q     <= 2'd0;
            conv_start_q <= 1'b0;
            busy_q       <= 1'b0;
            done_q       <= 1'b0;
        end else begin
            state_q      <= state_d;
            cfg_x_q      <= cfg_x_d;
            cfg_y_q      <= cfg_y_d;
            cfg_g_q      <= cfg_g_d;
            dma_req_q    <= dma_req_d;
            dma_op_q     <= dma_op_d;
            conv_start_q <= conv_start_d;
            busy_q       <= busy_d;
            done_q       <= done_d;
        end
    end

    assign bus.dma_req    = dma_req_q;
    assign bus.dma_op     = dma_op_q;
    assign bus.dma_tile_x = tx;
    assign bus.dma_tile_y = ty;
    assign bus.dma_group  = grp;
    assign bus.conv_start = conv_start_q;
    assign bus.busy       = busy_q;
    assign bus.done       = done_q;

`ifdef IRB_SCHED_PERF_EN
    logic [PERF_W-1:0] perf_busy_q, perf_busy_d, perf_stall_q, perf_stall_d;

    always_comb begin
        perf_busy_d  = perf_busy_q;
        perf_stall_d = perf_stall_q;
        if (start_acc) begin
            perf_busy_d  = '0;
            perf_stall_d = '0;
        end else begin
            if (busy_q && !(&perf_busy_q))
                perf_busy_d = perf_busy_q + PERF_W'(1);
            if (((dma_req_q && !bus.dma_ack) || state_q == ST_CONV_WAIT) && !(&perf_stall_q))
                perf_stall_d = perf_stall_q + PERF_W'(1);
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            perf_busy_q  <= '0;
            perf_stall_q <= '0;
        end else begin
            perf_busy_q  <= perf_busy_d;
            perf_stall_q <= perf_stall_d;
        end
    end

    assign perf_busy_cyc  = perf_busy_q;
    assign perf_stall_cyc = perf_stall_q;
`endif

endmodule
